fetch_unit: RTL and testbench

- Instruction fetch stage: the consumer of the branch unit's redirect interface (pc_update_control / pc_update_val).
- Holds the fetch PC and issues requests to instruction memory over a req/gnt/rvalid handshake, with at most one request outstanding.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode with a valid/ready handshake.
- On a redirect it flushes all wrong-path state, including any in-flight response, and restarts fetch at the target.

---
 rtl/fetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives a single-outstanding req/gnt/rvalid memory port,
// buffers {pc, inst} pairs in a small FIFO for decode and restarts fetch on branch redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        pc_update_control,
  input  logic [31:0] pc_update_val,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  input  logic        id_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DROP = 2'd3;

  logic [1:0]       state, state_nx;
  logic [31:0]      fetch_pc;
  logic [31:0]      issued_pc;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count, count_nx;
  logic [31:0]      pc_mem   [FIFO_DEPTH];
  logic [31:0]      inst_mem [FIFO_DEPTH];
  logic             redirect, granted, push, pop;
  logic             unused_tgt_bits;

  assign redirect = pc_update_control;
  assign granted  = (state == REQ) && imem_gnt;
  // A redirect flushes the FIFO, so any same-cycle push or pop is void.
  assign push     = (state == WAIT) && imem_rvalid && !redirect;
  assign pop      = if_valid && id_ready && !redirect;
  assign count_nx = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (redirect || (count < DEPTH_C)) state_nx = REQ;
      REQ:  if (imem_gnt) state_nx = redirect ? DROP : WAIT;
      WAIT: begin
        if (imem_rvalid)   state_nx = (redirect || (count_nx < DEPTH_C)) ? REQ : IDLE;
        else if (redirect) state_nx = DROP;
      end
      // The wrong-path response retires the outstanding request even if another redirect lands now.
      DROP: if (imem_rvalid) state_nx = REQ;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state <= state_nx;
      if (redirect)     fetch_pc <= {pc_update_val[31:2], 2'b00};
      else if (granted) fetch_pc <= fetch_pc + 32'd4;
      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count_nx;
      end
    end
  end

  // Payload storage carries no reset; emptiness is tracked by count alone.
  always_ff @(posedge i_clk) begin
    if (granted) issued_pc <= fetch_pc;
    if (push) begin
      pc_mem[wr_ptr]   <= issued_pc;
      inst_mem[wr_ptr] <= imem_rdata;
    end
  end

  assign imem_req  = (state == REQ);
  assign imem_addr = fetch_pc;
  assign if_valid  = (count != '0);
  assign if_pc     = if_valid ? pc_mem[rd_ptr]   : 32'd0;
  assign if_inst   = if_valid ? inst_mem[rd_ptr] : 32'd0;

  assign unused_tgt_bits = ^pc_update_val[1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a memory responder plus a queue-based model of the
// expected decode stream, fetch address and wrong-path dropping.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        pc_update_control = 1'b0;
  logic [31:0] pc_update_val = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        id_ready = 1'b0;

  fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .pc_update_control(pc_update_control), .pc_update_val(pc_update_val),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .id_ready(id_ready)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        q[$];
  int          n_cmp = 0, n_bad = 0;
  bit          outstanding = 0;
  logic [31:0] pend_addr = '0;
  int          pend_epoch = 0, pend_wait = 0, epoch = 0, stall = 0;
  logic [31:0] exp_fetch = RESET_PC;
  int          gnt_pct = 100, rdy_pct = 100, redir_pct = 0, spur_pct = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    outstanding = 0;
    epoch++;
    exp_fetch = RESET_PC;
    stall = 0;
  endtask

  // Compare outputs with the model, then advance the model by what the next edge will do.
  task automatic sample_and_step();
    bit redirect, pop, push;
    chk("if_valid", 32'(if_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("if_pc", if_pc, q[0].pc);
      chk("if_inst", if_inst, q[0].inst);
    end else begin
      chk("if_pc_empty", if_pc, 32'd0);
      chk("if_inst_empty", if_inst, 32'd0);
    end
    if (imem_req) begin
      chk("imem_addr", imem_addr, exp_fetch);
      chk("req_while_outstanding", 32'(outstanding), 32'd0);
      chk("req_fifo_room", 32'(q.size() < DEPTH), 32'd1);
    end
    if (!outstanding && !imem_req && q.size() < DEPTH) stall++;
    else stall = 0;
    chk("idle_stall", 32'(stall > 1), 32'd0);

    redirect = pc_update_control;
    pop      = (q.size() != 0) && id_ready;
    push     = 0;
    if (imem_rvalid && outstanding) begin
      push = (pend_epoch == epoch) && !redirect;
      outstanding = 0;
    end
    if (redirect) q.delete();
    else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back('{pc: pend_addr, inst: mem_word(pend_addr)});
    end
    if (imem_req && imem_gnt) begin
      outstanding = 1;
      pend_addr   = imem_addr;
      pend_epoch  = epoch;
      pend_wait   = int'($urandom_range(1, 3));
      exp_fetch   = exp_fetch + 32'd4;
    end
    if (redirect) begin
      epoch++;
      exp_fetch = {pc_update_val[31:2], 2'b00};
    end
  endtask

  task automatic drive();
    id_ready          = ($urandom_range(0, 99) < rdy_pct);
    pc_update_control = ($urandom_range(0, 99) < redir_pct);
    case ($urandom_range(0, 3))
      0:       pc_update_val = 32'h0000_0100;
      1:       pc_update_val = 32'h0000_0203;
      2:       pc_update_val = 32'hFFFF_FFF4 | 32'($urandom_range(0, 3));
      default: pc_update_val = $urandom;
    endcase
    imem_gnt = imem_req && ($urandom_range(0, 99) < gnt_pct);
    if (outstanding) begin
      pend_wait--;
      imem_rvalid = (pend_wait == 0);
      imem_rdata  = mem_word(pend_addr);
    end else begin
      imem_rvalid = ($urandom_range(0, 99) < spur_pct);
      imem_rdata  = $urandom;
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge i_clk);
      sample_and_step();
      @(posedge i_clk);
      #1;
      drive();
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b1;
    run(1);
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, RESET_PC);
    run(30);

    // Decode stalled: FIFO fills and requests stop.
    rdy_pct = 0;
    run(20);
    chk("full_valid", 32'(if_valid), 32'd1);
    chk("full_noreq", 32'(imem_req), 32'd0);

    // One pop, then a request held without grant gets redirected.
    rdy_pct = 100; gnt_pct = 0;
    run(1);
    rdy_pct = 0;
    run(3);
    chk("pre_redir_req", 32'(imem_req), 32'd1);
    chk("pre_redir_valid", 32'(if_valid), 32'd1);
    pc_update_control = 1'b1; pc_update_val = 32'h0000_0203; imem_gnt = 1'b0;
    run(1);
    chk("redir_req", 32'(imem_req), 32'd1);
    chk("redir_addr", imem_addr, 32'h0000_0200);
    chk("redir_flush", 32'(if_valid), 32'd0);

    // Redirect while waiting for a response.
    gnt_pct = 100; rdy_pct = 100;
    for (int i = 0; i < 40; i++) begin
      run(1);
      if (outstanding && pend_wait > 0) break;
    end
    pc_update_control = 1'b1; pc_update_val = 32'h0000_0100;
    run(1);
    for (int i = 0; i < 40; i++) begin
      if (if_valid) break;
      run(1);
    end
    chk("wait_redir_valid", 32'(if_valid), 32'd1);
    chk("wait_redir_pc", if_pc, 32'h0000_0100);

    // Redirect in the same cycle as a response and a pop.
    rdy_pct = 50;
    for (int i = 0; i < 200; i++) begin
      run(1);
      if (outstanding && pend_wait == 0 && if_valid) break;
    end
    id_ready = 1'b1; pc_update_control = 1'b1; pc_update_val = 32'h0000_0300;
    run(1);
    chk("rsp_redir_flush", 32'(if_valid), 32'd0);
    chk("rsp_redir_req", 32'(imem_req), 32'd1);
    chk("rsp_redir_addr", imem_addr, 32'h0000_0300);
    rdy_pct = 100;
    for (int i = 0; i < 40; i++) begin
      if (if_valid) break;
      run(1);
    end
    chk("rsp_redir_pc", if_pc, 32'h0000_0300);

    // Fetch address wraps past the top of memory.
    pc_update_control = 1'b1; pc_update_val = 32'hFFFF_FFF6;
    run(15);

    // Asynchronous reset while a response is pending.
    for (int i = 0; i < 40; i++) begin
      run(1);
      if (outstanding && pend_wait > 0) break;
    end
    #2 i_rst = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_pc", if_pc, 32'd0);
    model_reset();
    pc_update_control = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; id_ready = 1'b0;
    @(posedge i_clk);
    #1 i_rst = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = $urandom;
    run(1);
    chk("rst_first_req", 32'(imem_req), 32'd1);
    chk("rst_first_addr", imem_addr, RESET_PC);
    run(10);

    // Mixed random traffic.
    gnt_pct = 60; rdy_pct = 70; redir_pct = 3; spur_pct = 10;
    run(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
